dnpcie_aurora_link_monitor: RTL and testbench

- Link-side counterpart of the Aurora reset controller: watches channel/lane status and decides when a reset is required, driving the controller's ext_reset and consuming its reset_busy.
- Implements a local hotplug timeout: if the channel has not come up within a programmable number of init_clk cycles, or drops and stays down past a debounce window, it requests a reset.
- Runs entirely on init_clk; status inputs from user_clk/GT domains are synchronized internally.

---
 rtl/dnpcie_aurora_pkg.sv | 27 ++
 rtl/dnpcie_sync_bit.sv | 29 ++
 rtl/dnpcie_aurora_link_monitor.sv | 179 +++++++++++++++++
 tb/tb_dnpcie_aurora_link_monitor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dnpcie_aurora_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dnpcie_aurora_pkg
// Purpose : Shared constants and helpers for the Aurora reset/monitor blocks.
// Revision: 1.0 - initial release
// ============================================================================
package dnpcie_aurora_pkg;

  localparam int HOTPLUG_W = 48;

  localparam logic [2:0] ST_DISABLED  = 3'd0;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd1;
  localparam logic [2:0] ST_WAIT_UP   = 3'd2;
  localparam logic [2:0] ST_UP        = 3'd3;
  localparam logic [2:0] ST_LOSS      = 3'd4;
  localparam logic [2:0] ST_REQ       = 3'd5;
  localparam logic [2:0] ST_ACK       = 3'd6;

  // A zero timeout would never match an incrementing timer, so treat it as one cycle.
  function automatic logic [HOTPLUG_W-1:0] hotplug_limit(input logic [HOTPLUG_W-1:0] wait_cycles);
    logic [HOTPLUG_W-1:0] one;
    one = {{(HOTPLUG_W-1){1'b0}}, 1'b1};
    return (wait_cycles == '0) ? one : wait_cycles;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dnpcie_sync_bit.sv
`default_nettype none
// ============================================================================
// Module  : dnpcie_sync_bit
// Purpose : Multi-flop single-bit synchronizer, cleared to 0 on reset.
// Revision: 1.0 - initial release
// ============================================================================
module dnpcie_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/dnpcie_aurora_link_monitor.sv
`default_nettype none
// ============================================================================
// Module  : dnpcie_aurora_link_monitor
// Purpose : Watches Aurora channel/lane status and requests resets from the
//           reset controller on hotplug timeout, link loss or software request.
// Revision: 1.0 - initial release
// ============================================================================
module dnpcie_aurora_link_monitor
  import dnpcie_aurora_pkg::*;
#(
  parameter int NUM_LANES     = 4,
  parameter int LOSS_DEBOUNCE = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_BITS      = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic                 channel_up_i,
  input  logic [NUM_LANES-1:0] lane_up_i,
  input  logic                 reset_busy_i,
  input  logic [HOTPLUG_W-1:0] hotplug_wait_i,
  input  logic                 force_reset_i,
  output logic                 ext_reset_o,
  output logic                 link_ok_o,
  output logic [2:0]           state_o,
  output logic [CNT_BITS-1:0]  link_loss_count_o,
  output logic [CNT_BITS-1:0]  reset_req_count_o
);

  localparam logic [7:0] c_deb_last = 8'(LOSS_DEBOUNCE - 1);

  logic w_chup_s;
  logic w_lanes_s;
  logic w_busy_s;
  logic w_link_s;

  dnpcie_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_chup (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (channel_up_i),
    .q_o     (w_chup_s)
  );

  dnpcie_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lanes (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (&lane_up_i),
    .q_o     (w_lanes_s)
  );

  dnpcie_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_busy (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (reset_busy_i),
    .q_o     (w_busy_s)
  );

  assign w_link_s = w_chup_s & w_lanes_s;

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [HOTPLUG_W-1:0] r_timer;
  logic [HOTPLUG_W-1:0] r_hp_lat;
  logic [HOTPLUG_W-1:0] w_timer_inc;
  logic [7:0]           r_deb;
  logic                 r_ext_reset;
  logic                 r_link_ok;
  logic [CNT_BITS-1:0]  r_loss_cnt;
  logic [CNT_BITS-1:0]  r_req_cnt;
  logic                 w_loss_decl;
  logic                 w_ext_reset_nxt;
  logic                 w_link_ok_nxt;
  logic                 w_wait_entry;
  logic                 w_loss_entry;
  logic                 w_req_entry;

  assign w_timer_inc = r_timer + 1'b1;

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_DISABLED;
      r_ext_reset <= 1'b0;
      r_link_ok   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ext_reset <= w_ext_reset_nxt;
      r_link_ok   <= w_link_ok_nxt;
    end
  end

  // Next-state logic; force_reset_i is honoured only in the link-watching states
  always_comb begin
    w_state_nxt = r_state;
    w_loss_decl = 1'b0;
    if (!enable_i) begin
      w_state_nxt = ST_DISABLED;
    end else begin
      case (r_state)
        ST_DISABLED:  w_state_nxt = ST_WAIT_IDLE;
        ST_WAIT_IDLE: begin
          if (force_reset_i)  w_state_nxt = ST_REQ;
          else if (!w_busy_s) w_state_nxt = ST_WAIT_UP;
        end
        ST_WAIT_UP: begin
          if (force_reset_i)                  w_state_nxt = ST_REQ;
          else if (w_link_s)                  w_state_nxt = ST_UP;
          else if (w_timer_inc == r_hp_lat)   w_state_nxt = ST_REQ;
        end
        ST_UP: begin
          if (force_reset_i)  w_state_nxt = ST_REQ;
          else if (!w_link_s) w_state_nxt = ST_LOSS;
        end
        ST_LOSS: begin
          if (force_reset_i) begin
            w_state_nxt = ST_REQ;
          end else if (w_link_s) begin
            w_state_nxt = ST_UP;
          end else if (r_deb == c_deb_last) begin
            w_state_nxt = ST_REQ;
            w_loss_decl = 1'b1;
          end
        end
        ST_REQ: if (w_busy_s)  w_state_nxt = ST_ACK;
        ST_ACK: if (!w_busy_s) w_state_nxt = ST_WAIT_UP;
        default: w_state_nxt = ST_DISABLED;
      endcase
    end
  end

  // Output / event decode from the upcoming state
  always_comb begin
    w_ext_reset_nxt = (w_state_nxt == ST_REQ);
    w_link_ok_nxt   = (w_state_nxt == ST_UP);
    w_wait_entry    = (w_state_nxt == ST_WAIT_UP) && (r_state != ST_WAIT_UP);
    w_loss_entry    = (w_state_nxt == ST_LOSS) && (r_state != ST_LOSS);
    w_req_entry     = (w_state_nxt == ST_REQ) && (r_state != ST_REQ);
  end

  // Hotplug timer, loss debounce and saturating event counters
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_timer    <= '0;
      r_hp_lat   <= '0;
      r_deb      <= '0;
      r_loss_cnt <= '0;
      r_req_cnt  <= '0;
    end else begin
      if (w_wait_entry) begin
        r_timer  <= '0;
        r_hp_lat <= hotplug_limit(hotplug_wait_i);
      end else if (r_state == ST_WAIT_UP) begin
        r_timer <= w_timer_inc;
      end

      if (w_loss_entry) begin
        r_deb <= '0;
      end else if (r_state == ST_LOSS) begin
        r_deb <= r_deb + 1'b1;
      end

      if (w_loss_decl && (r_loss_cnt != '1)) begin
        r_loss_cnt <= r_loss_cnt + 1'b1;
      end
      if (w_req_entry && (r_req_cnt != '1)) begin
        r_req_cnt <= r_req_cnt + 1'b1;
      end
    end
  end

  assign ext_reset_o       = r_ext_reset;
  assign link_ok_o         = r_link_ok;
  assign state_o           = r_state;
  assign link_loss_count_o = r_loss_cnt;
  assign reset_req_count_o = r_req_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dnpcie_aurora_link_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_dnpcie_aurora_link_monitor
// Purpose : Directed self-checking bench for the Aurora link monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dnpcie_aurora_link_monitor;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        chup;
  logic [3:0]  lanes;
  logic        busy;
  logic [47:0] hp_wait;
  logic        force_rst;

  logic        ext_reset;
  logic        link_ok;
  logic [2:0]  state;
  logic [15:0] loss_cnt;
  logic [15:0] req_cnt;

  logic        sat_ext_reset;
  logic        sat_link_ok;
  logic [2:0]  sat_state;
  logic [1:0]  sat_loss_cnt;
  logic [1:0]  sat_req_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  dnpcie_aurora_link_monitor dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .enable_i          (enable),
    .channel_up_i      (chup),
    .lane_up_i         (lanes),
    .reset_busy_i      (busy),
    .hotplug_wait_i    (hp_wait),
    .force_reset_i     (force_rst),
    .ext_reset_o       (ext_reset),
    .link_ok_o         (link_ok),
    .state_o           (state),
    .link_loss_count_o (loss_cnt),
    .reset_req_count_o (req_cnt)
  );

  dnpcie_aurora_link_monitor #(.CNT_BITS(2)) dut_sat (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .enable_i          (enable),
    .channel_up_i      (chup),
    .lane_up_i         (lanes),
    .reset_busy_i      (busy),
    .hotplug_wait_i    (hp_wait),
    .force_reset_i     (force_rst),
    .ext_reset_o       (sat_ext_reset),
    .link_ok_o         (sat_link_ok),
    .state_o           (sat_state),
    .link_loss_count_o (sat_loss_cnt),
    .reset_req_count_o (sat_req_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    tick(3);
    n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (ext_reset !== 1'b0) begin n_fail++; $display("FAIL reset_ext: got %0b want 0", ext_reset); end
    n_cmp++; if (link_ok !== 1'b0) begin n_fail++; $display("FAIL reset_link_ok: got %0b want 0", link_ok); end
    n_cmp++; if (loss_cnt !== 16'd0 || req_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", loss_cnt, req_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_power_on();
    enable = 1'b1;
    tick(40);
    chup = 1'b1; lanes = 4'hF;
    tick(8);
    n_cmp++; if (state !== 3'd3) begin n_fail++; $display("FAIL pwr_state: got %0d want 3", state); end
    n_cmp++; if (link_ok !== 1'b1) begin n_fail++; $display("FAIL pwr_link_ok: got %0b want 1", link_ok); end
    n_cmp++; if (ext_reset !== 1'b0) begin n_fail++; $display("FAIL pwr_ext: got %0b want 0", ext_reset); end
    n_cmp++; if (req_cnt !== 16'd0 || loss_cnt !== 16'd0) begin n_fail++; $display("FAIL pwr_counts: got %0d/%0d want 0/0", loss_cnt, req_cnt); end
  endtask

  task automatic test_timeout();
    enable = 1'b0; chup = 1'b0; lanes = 4'h0; hp_wait = 48'd50;
    tick(4);
    // WAIT_IDLE after 1 edge, WAIT_UP after 2, REQ 50 edges later
    enable = 1'b1;
    tick(51);
    n_cmp++; if (state !== 3'd2 || ext_reset !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got state %0d ext %0b want 2/0", state, ext_reset); end
    tick(1);
    n_cmp++; if (state !== 3'd5 || ext_reset !== 1'b1) begin n_fail++; $display("FAIL tmo_req: got state %0d ext %0b want 5/1", state, ext_reset); end
    n_cmp++; if (req_cnt !== 16'd1) begin n_fail++; $display("FAIL tmo_req_cnt: got %0d want 1", req_cnt); end
    busy = 1'b1;
    tick(4);
    n_cmp++; if (state !== 3'd6 || ext_reset !== 1'b0) begin n_fail++; $display("FAIL tmo_ack: got state %0d ext %0b want 6/0", state, ext_reset); end
    tick(16);
    busy = 1'b0;
    tick(4);
    n_cmp++; if (state !== 3'd2 || req_cnt !== 16'd1) begin n_fail++; $display("FAIL tmo_rewait: got state %0d cnt %0d want 2/1", state, req_cnt); end
    chup = 1'b1; lanes = 4'hF;
    tick(5);
    n_cmp++; if (state !== 3'd3) begin n_fail++; $display("FAIL tmo_up: got %0d want 3", state); end
  endtask

  task automatic test_debounce();
    chup = 1'b0;
    tick(5);
    n_cmp++; if (state !== 3'd4 || link_ok !== 1'b0) begin n_fail++; $display("FAIL deb_loss: got state %0d ok %0b want 4/0", state, link_ok); end
    tick(5);
    chup = 1'b1;
    tick(6);
    n_cmp++; if (state !== 3'd3 || loss_cnt !== 16'd0 || req_cnt !== 16'd1) begin n_fail++; $display("FAIL deb_short: got state %0d loss %0d req %0d want 3/0/1", state, loss_cnt, req_cnt); end
    // LOSS entered 3 edges after the drop, REQ after 16 LOSS cycles
    chup = 1'b0;
    tick(18);
    n_cmp++; if (state !== 3'd4) begin n_fail++; $display("FAIL deb_hold: got %0d want 4", state); end
    tick(1);
    n_cmp++; if (state !== 3'd5 || ext_reset !== 1'b1) begin n_fail++; $display("FAIL deb_req: got state %0d ext %0b want 5/1", state, ext_reset); end
    n_cmp++; if (loss_cnt !== 16'd1 || req_cnt !== 16'd2) begin n_fail++; $display("FAIL deb_counts: got %0d/%0d want 1/2", loss_cnt, req_cnt); end
    tick(11);
    busy = 1'b1;
    tick(5);
    busy = 1'b0; chup = 1'b1;
    tick(6);
    n_cmp++; if (state !== 3'd3) begin n_fail++; $display("FAIL deb_recover: got %0d want 3", state); end
  endtask

  task automatic test_force();
    force_rst = 1'b1;
    tick(1);
    force_rst = 1'b0;
    n_cmp++; if (state !== 3'd5 || ext_reset !== 1'b1 || req_cnt !== 16'd3) begin n_fail++; $display("FAIL frc_req: got state %0d ext %0b cnt %0d want 5/1/3", state, ext_reset, req_cnt); end
    busy = 1'b1;
    tick(4);
    n_cmp++; if (state !== 3'd6) begin n_fail++; $display("FAIL frc_ack: got %0d want 6", state); end
    force_rst = 1'b1;
    tick(1);
    force_rst = 1'b0;
    tick(1);
    n_cmp++; if (state !== 3'd6 || req_cnt !== 16'd3 || ext_reset !== 1'b0) begin n_fail++; $display("FAIL frc_ignored: got state %0d cnt %0d ext %0b want 6/3/0", state, req_cnt, ext_reset); end
    busy = 1'b0;
    tick(5);
    n_cmp++; if (state !== 3'd3) begin n_fail++; $display("FAIL frc_up: got %0d want 3", state); end
  endtask

  task automatic test_disable_mid_req();
    force_rst = 1'b1;
    tick(1);
    force_rst = 1'b0;
    n_cmp++; if (ext_reset !== 1'b1 || req_cnt !== 16'd4) begin n_fail++; $display("FAIL dis_req: got ext %0b cnt %0d want 1/4", ext_reset, req_cnt); end
    enable = 1'b0;
    tick(1);
    n_cmp++; if (ext_reset !== 1'b0 || state !== 3'd0) begin n_fail++; $display("FAIL dis_drop: got ext %0b state %0d want 0/0", ext_reset, state); end
    chup = 1'b0; lanes = 4'h0; hp_wait = 48'd1000; busy = 1'b1;
    tick(4);
    enable = 1'b1;
    tick(6);
    n_cmp++; if (state !== 3'd1) begin n_fail++; $display("FAIL dis_idle_hold: got %0d want 1", state); end
    busy = 1'b0;
    tick(5);
    n_cmp++; if (state !== 3'd2) begin n_fail++; $display("FAIL dis_wait_up: got %0d want 2", state); end
  endtask

  task automatic test_edge_saturation();
    enable = 1'b0; hp_wait = 48'd0;
    tick(2);
    enable = 1'b1;
    tick(2);
    n_cmp++; if (state !== 3'd2) begin n_fail++; $display("FAIL hp0_wait: got %0d want 2", state); end
    tick(1);
    n_cmp++; if (state !== 3'd5 || ext_reset !== 1'b1 || req_cnt !== 16'd5) begin n_fail++; $display("FAIL hp0_req: got state %0d ext %0b cnt %0d want 5/1/5", state, ext_reset, req_cnt); end
    busy = 1'b1;
    tick(5);
    busy = 1'b0;
    tick(8);
    n_cmp++; if (state !== 3'd5 || req_cnt !== 16'd6) begin n_fail++; $display("FAIL hp0_rereq: got state %0d cnt %0d want 5/6", state, req_cnt); end
    n_cmp++; if (sat_req_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_req_cnt: got %0d want 3", sat_req_cnt); end
    n_cmp++; if (sat_loss_cnt !== 2'd1 || loss_cnt !== 16'd1) begin n_fail++; $display("FAIL loss_cnts: got %0d/%0d want 1/1", sat_loss_cnt, loss_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; chup = 1'b0; lanes = 4'h0;
    busy = 1'b0; hp_wait = 48'd100; force_rst = 1'b0;
    test_reset();
    test_power_on();
    test_timeout();
    test_debounce();
    test_force();
    test_disable_mid_req();
    test_edge_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
